rd_arbiter: RTL and testbench

- Shares one single-port read resource between N_REQ requesters, using a round-robin grant.
- Sequences the read handshake for the granted requester: IDLE -> READ -> DLY -> DONE, with wait-state extension via ws.
- Returns a one-cycle per-requester done pulse.
- Sits between client request logic and the memory read strobe and wait-state interface.

---
 rtl/rd_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rd_arbiter.sv | 119 +++++++++++
 tb/tb_rd_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rd_arb_pkg.sv
// Shared types and helpers for the read-resource arbiter.
// Holds the transaction state encoding and the one-hot decode helper.
package rd_arb_pkg;

  // Upper bound on requesters.
  // Sizes the one-hot helper so that one function serves every N_REQ.
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DLY  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Returns a one-hot vector with bit idx set.
  // Bits at or above n are never set, so callers can truncate safely.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] idx,
                                                input int                  n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && idx == MAX_ID_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first asserted request, searching from ptr+1 upward and wrapping
// modulo N_REQ, so the last winner (ptr) gets the lowest priority.
// Reusable by any arbiter that keeps its own pointer register.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  // Priority search from the requester after ptr; the first hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise the paths that skip an assignment infer a latch.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rd_arbiter.sv
// Round-robin arbiter for a single-port read resource.
// The granted requester is walked through IDLE -> READ -> DLY -> DONE.
// While ws=1 is seen in DLY, the READ/DLY loop repeats.
// DONE issues a one-cycle done strobe to the granted requester.
// All outputs are registered, so no path runs from req or ws to an output.
// Optional build macro: RD_ARB_TIMEOUT_EN. When it is defined, the macro
// bounds the wait-state loops at WAIT_MAX and adds the err output.
module rd_arbiter
  import rd_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WAIT_MAX = 15,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ws,
  output logic             rd,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic [N_REQ-1:0] ds,
  output logic             busy
`ifdef RD_ARB_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  state_e          state;
  logic [ID_W-1:0] ptr;
  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;

`ifdef RD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] loop_cnt;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Transaction FSM with registered outputs and the round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // Every register then updates from pre-edge values, so no ordering
    // races occur between blocks.
    if (rst) begin
      state  <= IDLE;
      rd     <= 1'b0;
      gnt    <= '0;
      gnt_id <= '0;
      ds     <= '0;
      busy   <= 1'b0;
      ptr    <= ID_W'(N_REQ - 1);
`ifdef RD_ARB_TIMEOUT_EN
      loop_cnt <= '0;
      err      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state  <= READ;
            gnt    <= N_REQ'(onehot(MAX_ID_W'(pick_idx), N_REQ));
            gnt_id <= pick_idx;
            rd     <= 1'b1;
            busy   <= 1'b1;
`ifdef RD_ARB_TIMEOUT_EN
            loop_cnt <= '0;
`endif
          end
        end
        READ: begin
          state <= DLY;
        end
        DLY: begin
          if (ws) begin
`ifdef RD_ARB_TIMEOUT_EN
            if (loop_cnt == CNT_W'(WAIT_MAX)) begin
              // The resource never became ready; abort with an error strobe.
              state <= DONE;
              rd    <= 1'b0;
              ds    <= N_REQ'(onehot(MAX_ID_W'(gnt_id), N_REQ));
              err   <= 1'b1;
            end else begin
              state    <= READ;
              loop_cnt <= loop_cnt + CNT_W'(1);
            end
`else
            state <= READ;
`endif
          end else begin
            state <= DONE;
            rd    <= 1'b0;
            ds    <= N_REQ'(onehot(MAX_ID_W'(gnt_id), N_REQ));
          end
        end
        DONE: begin
          state  <= IDLE;
          ds     <= '0;
          gnt    <= '0;
          gnt_id <= '0;
          busy   <= 1'b0;
          ptr    <= gnt_id;
`ifdef RD_ARB_TIMEOUT_EN
          err    <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_arbiter.sv
// Directed testbench for rd_arbiter (N_REQ=4).
// Covers reset, single transactions, wait states, round-robin order,
// a req drop mid-transaction and reset in DLY.
// When RD_ARB_TIMEOUT_EN is defined, it also covers the WAIT_MAX=3 abort.
module tb_rd_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ws;
  logic       rd;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] ds;
  logic       busy;
`ifdef RD_ARB_TIMEOUT_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  rd_arbiter #(.N_REQ(4), .WAIT_MAX(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ws     (ws),
    .rd     (rd),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .ds     (ds),
    .busy   (busy)
`ifdef RD_ARB_TIMEOUT_EN
    ,
    .err    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_rd, input logic [3:0] e_gnt,
                         input logic [1:0] e_id, input logic [3:0] e_ds,
                         input logic e_busy, input logic e_err);
    check({tag, ".rd"},     32'(rd),     32'(e_rd));
    check({tag, ".gnt"},    32'(gnt),    32'(e_gnt));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
    check({tag, ".ds"},     32'(ds),     32'(e_ds));
    check({tag, ".busy"},   32'(busy),   32'(e_busy));
`ifdef RD_ARB_TIMEOUT_EN
    check({tag, ".err"},    32'(err),    32'(e_err));
`else
    if (e_err) $display("note: err expectation ignored without timeout build");
`endif
  endtask

  initial begin
    int rr_exp [6];
    rr_exp = '{0, 1, 2, 3, 0, 1};

    // Reset held with all requests pending: outputs stay quiet.
    rst = 1'b1; req = 4'b1111; ws = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("reset%0d", i), 0, 4'b0000, 0, 4'b0000, 0, 0);
    end

    // First grant after release goes to requester 0.
    rst = 1'b0;
    tick(); chk_out("first_read", 1, 4'b0001, 0, 4'b0000, 1, 0);
    req = 4'b0000;
    tick(); chk_out("first_dly",  1, 4'b0001, 0, 4'b0000, 1, 0);
    tick(); chk_out("first_done", 0, 4'b0001, 0, 4'b0001, 1, 0);
    tick(); chk_out("first_idle", 0, 4'b0000, 0, 4'b0000, 0, 0);
    tick(); chk_out("idle_hold",  0, 4'b0000, 0, 4'b0000, 0, 0);

    // Single request, no wait states.
    req = 4'b0100;
    tick(); chk_out("single_read", 1, 4'b0100, 2, 4'b0000, 1, 0);
    req = 4'b0000;
    tick(); chk_out("single_dly",  1, 4'b0100, 2, 4'b0000, 1, 0);
    tick(); chk_out("single_done", 0, 4'b0100, 2, 4'b0100, 1, 0);
    tick(); chk_out("single_idle", 0, 4'b0000, 0, 4'b0000, 0, 0);

    // Two ws=1 samples in DLY: rd is high for six cycles.
    req = 4'b0010;
    tick(); chk_out("ws_c1", 1, 4'b0010, 1, 4'b0000, 1, 0);
    req = 4'b0000; ws = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      tick(); chk_out($sformatf("ws_c%0d", c), 1, 4'b0010, 1, 4'b0000, 1, 0);
      if (c == 5) ws = 1'b0;
    end
    tick(); chk_out("ws_done", 0, 4'b0010, 1, 4'b0010, 1, 0);
    tick(); chk_out("ws_idle", 0, 4'b0000, 0, 4'b0000, 0, 0);

    // Round-robin with every requester pending, starting from reset pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      logic [3:0] oh;
      oh = 4'b0001 << rr_exp[t];
      tick();
      check($sformatf("rr%0d.gnt_id", t), 32'(gnt_id), 32'(rr_exp[t]));
      check($sformatf("rr%0d.gnt", t),    32'(gnt),    32'(oh));
      tick(); tick();
      check($sformatf("rr%0d.ds", t),     32'(ds),     32'(oh));
      req[rr_exp[t]] = 1'b0;
      tick();
      check($sformatf("rr%0d.idle", t),   32'(busy),   32'(0));
      req = 4'b1111;
    end
    req = 4'b0000;

    // Reset in DLY: no done strobe, and the pointer returns to N_REQ-1.
    req = 4'b0100;
    tick(); chk_out("rstdly_read", 1, 4'b0100, 2, 4'b0000, 1, 0);
    req = 4'b0000;
    tick(); chk_out("rstdly_dly",  1, 4'b0100, 2, 4'b0000, 1, 0);
    rst = 1'b1;
    tick(); chk_out("rstdly_rst",  0, 4'b0000, 0, 4'b0000, 0, 0);
    rst = 1'b0;
    tick(); chk_out("rstdly_quiet", 0, 4'b0000, 0, 4'b0000, 0, 0);
    req = 4'b0110;
    tick(); chk_out("rstdly_regrant", 1, 4'b0010, 1, 4'b0000, 1, 0);
    req = 4'b0000;
    tick();
    tick(); chk_out("rstdly_done", 0, 4'b0010, 1, 4'b0010, 1, 0);
    tick();

    // Granted requester drops req during READ: the transaction still completes.
    req = 4'b1000;
    tick(); chk_out("drop_read", 1, 4'b1000, 3, 4'b0000, 1, 0);
    req = 4'b0000;
    tick(); chk_out("drop_dly",  1, 4'b1000, 3, 4'b0000, 1, 0);
    tick(); chk_out("drop_done", 0, 4'b1000, 3, 4'b1000, 1, 0);
    tick(); chk_out("drop_idle", 0, 4'b0000, 0, 4'b0000, 0, 0);

`ifdef RD_ARB_TIMEOUT_EN
    // ws stuck high: three loops back to READ, then abort with err and ds.
    req = 4'b0001; ws = 1'b1;
    tick(); chk_out("to_c1", 1, 4'b0001, 0, 4'b0000, 1, 0);
    req = 4'b0000;
    for (int c = 2; c <= 8; c++) begin
      tick(); chk_out($sformatf("to_c%0d", c), 1, 4'b0001, 0, 4'b0000, 1, 0);
    end
    tick(); chk_out("to_done", 0, 4'b0001, 0, 4'b0001, 1, 1);
    tick(); chk_out("to_idle", 0, 4'b0000, 0, 4'b0000, 0, 0);
    ws = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
